// File: rtl/mem_wb_pipe.sv
// MEM->WB stage register: LANES write channels, DEPTH stages, stall/flush, x0 write
// suppression, combinational forwarding over in-flight writes and a retired-write counter.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [LANES*ADDR_W-1:0]   mem_waddr,
  input  logic [LANES-1:0]          mem_we,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  output logic [LANES*ADDR_W-1:0]   wb_waddr,
  output logic [LANES-1:0]          wb_we,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  input  logic [ADDR_W-1:0]         fwd_raddr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [CNT_W-1:0]          retire_cnt
);

  // Index 0 is S1 (youngest), DEPTH-1 is the stage driving wb_*.
  logic [LANES-1:0]        st_we   [DEPTH];
  logic [LANES*ADDR_W-1:0] st_addr [DEPTH];
  logic [LANES*DATA_W-1:0] st_data [DEPTH];

  logic [LANES-1:0] in_we;
  logic [CNT_W-1:0] retire_inc;

  always_comb begin
    in_we = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      in_we[l] = mem_we[l] && (mem_waddr[l*ADDR_W +: ADDR_W] != '0);
    end
  end

  always_comb begin
    retire_inc = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      retire_inc = retire_inc + CNT_W'(st_we[DEPTH-1][l]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        st_we[s]   <= '0;
        st_addr[s] <= '0;
        st_data[s] <= '0;
      end
      retire_cnt <= '0;
    end else if (flush) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        st_we[s]   <= '0;
        st_addr[s] <= '0;
        st_data[s] <= '0;
      end
      retire_cnt <= retire_cnt + retire_inc;
    end else if (!stall) begin
      st_we[0]   <= in_we;
      st_addr[0] <= mem_waddr;
      st_data[0] <= mem_wdata;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        st_we[s]   <= st_we[s-1];
        st_addr[s] <= st_addr[s-1];
        st_data[s] <= st_data[s-1];
      end
      retire_cnt <= retire_cnt + retire_inc;
    end
  end

  assign wb_we    = st_we[DEPTH-1];
  assign wb_waddr = st_addr[DEPTH-1];
  assign wb_wdata = st_data[DEPTH-1];

  // Scan oldest stage/lowest lane first so the last match is the youngest write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_raddr != '0) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (st_we[DEPTH-1-s][l] &&
              (st_addr[DEPTH-1-s][l*ADDR_W +: ADDR_W] == fwd_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = st_data[DEPTH-1-s][l*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule
